// File: rtl/match_controller.sv
// Head-soccer match sequencer: owns match state, scores and match clock,
// and gates ball physics and ball re-centring for the datapath.
module match_controller #(
  parameter logic [25:0] TICKS_PER_SEC      = 26'd50_000_000,
  parameter logic [6:0]  MATCH_SECONDS      = 7'd90,
  parameter logic [2:0]  KICKOFF_SECONDS    = 3'd3,
  parameter logic [2:0]  GOAL_PAUSE_SECONDS = 3'd2,
  parameter logic [3:0]  MAX_SCORE          = 4'd9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       startButton,
  input  logic       pauseButton,
  input  logic [1:0] goal,
  output logic       gameStart,
  output logic       ballReset,
  output logic [3:0] scoreA,
  output logic [3:0] scoreB,
  output logic [6:0] timeLeft,
  output logic [2:0] countdown,
  output logic [1:0] winner,
  output logic [2:0] matchState
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_KICKOFF    = 3'd1,
    S_PLAY       = 3'd2,
    S_PAUSED     = 3'd3,
    S_GOAL_PAUSE = 3'd4,
    S_GAME_OVER  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [25:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]  score_a_q, score_a_d;
  logic [3:0]  score_b_q, score_b_d;
  logic [6:0]  time_left_q, time_left_d;
  logic [2:0]  countdown_q, countdown_d;
  logic [2:0]  pause_cnt_q, pause_cnt_d;
  logic [1:0]  winner_q, winner_d;

  logic start_prev_q, pause_prev_q, goal_prev_q;
  logic start_edge_q, pause_edge_q, goal_edge_q;
  logic goal_side_q;
  logic start_edge_d, pause_edge_d, goal_edge_d;

  logic       counting, sec_tick, final_tick;
  logic       a_goal, b_goal, goal_max;
  logic [3:0] score_a_inc, score_b_inc;

  // Edges are registered, so a button edge reaches the FSM one cycle late.
  always_comb begin
    start_edge_d = startButton & ~start_prev_q;
    pause_edge_d = pauseButton & ~pause_prev_q;
    goal_edge_d  = goal[1] & ~goal_prev_q;
  end

  always_comb begin
    counting = (state_q == S_KICKOFF) || (state_q == S_PLAY) ||
               (state_q == S_GOAL_PAUSE);
    sec_tick   = counting && (tick_cnt_q == TICKS_PER_SEC - 26'd1);
    final_tick = sec_tick && (time_left_q <= 7'd1);
    a_goal     = goal_edge_q & goal_side_q;
    b_goal     = goal_edge_q & ~goal_side_q;
    score_a_inc = (score_a_q < MAX_SCORE) ? score_a_q + 4'd1 : score_a_q;
    score_b_inc = (score_b_q < MAX_SCORE) ? score_b_q + 4'd1 : score_b_q;
    goal_max = a_goal ? (score_a_inc == MAX_SCORE)
                      : (score_b_inc == MAX_SCORE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tick_cnt_q   <= '0;
      score_a_q    <= '0;
      score_b_q    <= '0;
      time_left_q  <= MATCH_SECONDS;
      countdown_q  <= '0;
      pause_cnt_q  <= '0;
      winner_q     <= '0;
      start_prev_q <= 1'b0;
      pause_prev_q <= 1'b0;
      goal_prev_q  <= 1'b0;
      start_edge_q <= 1'b0;
      pause_edge_q <= 1'b0;
      goal_edge_q  <= 1'b0;
      goal_side_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      score_a_q    <= score_a_d;
      score_b_q    <= score_b_d;
      time_left_q  <= time_left_d;
      countdown_q  <= countdown_d;
      pause_cnt_q  <= pause_cnt_d;
      winner_q     <= winner_d;
      start_prev_q <= startButton;
      pause_prev_q <= pauseButton;
      goal_prev_q  <= goal[1];
      start_edge_q <= start_edge_d;
      pause_edge_q <= pause_edge_d;
      goal_edge_q  <= goal_edge_d;
      goal_side_q  <= goal[0];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_edge_q) state_d = S_KICKOFF;
      end
      S_KICKOFF: begin
        if (sec_tick && countdown_q <= 3'd1) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (goal_edge_q) begin
          if (goal_max || final_tick) state_d = S_GAME_OVER;
          else                        state_d = S_GOAL_PAUSE;
        end else if (final_tick) begin
          state_d = S_GAME_OVER;
        end else if (pause_edge_q) begin
          state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (pause_edge_q) state_d = S_PLAY;
      end
      S_GOAL_PAUSE: begin
        if (sec_tick && pause_cnt_q <= 3'd1) state_d = S_KICKOFF;
      end
      S_GAME_OVER: begin
        if (start_edge_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    score_a_d   = score_a_q;
    score_b_d   = score_b_q;
    time_left_d = time_left_q;
    countdown_d = countdown_q;
    pause_cnt_d = pause_cnt_q;
    winner_d    = winner_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_edge_q) countdown_d = KICKOFF_SECONDS;
      end
      S_KICKOFF: begin
        if (sec_tick && countdown_q != 3'd0)
          countdown_d = countdown_q - 3'd1;
      end
      S_PLAY: begin
        if (sec_tick && time_left_q != 7'd0)
          time_left_d = time_left_q - 7'd1;
        if (a_goal) score_a_d = score_a_inc;
        if (b_goal) score_b_d = score_b_inc;
        if (state_d == S_GOAL_PAUSE) pause_cnt_d = GOAL_PAUSE_SECONDS;
      end
      S_GOAL_PAUSE: begin
        if (sec_tick && pause_cnt_q != 3'd0)
          pause_cnt_d = pause_cnt_q - 3'd1;
        if (state_d == S_KICKOFF) countdown_d = KICKOFF_SECONDS;
      end
      default: ;
    endcase
    if (state_d == S_IDLE) begin
      score_a_d   = '0;
      score_b_d   = '0;
      time_left_d = MATCH_SECONDS;
      winner_d    = 2'b00;
    end
    if (state_d == S_GAME_OVER && state_q != S_GAME_OVER) begin
      if (score_a_d > score_b_d)      winner_d = 2'b01;
      else if (score_b_d > score_a_d) winner_d = 2'b10;
      else                            winner_d = 2'b11;
    end
  end

  // Pause freezes the prescaler phase so resumed play keeps its cadence.
  always_comb begin
    tick_cnt_d = '0;
    if (state_q == S_PAUSED)
      tick_cnt_d = tick_cnt_q;
    else if (state_d == S_PAUSED)
      tick_cnt_d = sec_tick ? '0 : tick_cnt_q;
    else if (state_d != state_q)
      tick_cnt_d = '0;
    else if (counting)
      tick_cnt_d = sec_tick ? '0 : tick_cnt_q + 26'd1;
  end

  always_comb begin
    gameStart = 1'b0;
    ballReset = 1'b0;
    unique case (state_q)
      S_IDLE, S_KICKOFF, S_GOAL_PAUSE: ballReset = 1'b1;
      S_PLAY:                          gameStart = 1'b1;
      default: ;
    endcase
    matchState = state_q;
    scoreA     = score_a_q;
    scoreB     = score_b_q;
    timeLeft   = time_left_q;
    countdown  = countdown_q;
    winner     = winner_q;
  end

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with small timing parameters
// (4 ticks/s, 5 s match, 2 s kickoff, 1 s goal pause, max score 3).
module tb_match_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       startButton, pauseButton;
  logic [1:0] goal;
  logic       gameStart, ballReset;
  logic [3:0] scoreA, scoreB;
  logic [6:0] timeLeft;
  logic [2:0] countdown;
  logic [1:0] winner;
  logic [2:0] matchState;

  int n_cmp = 0;
  int n_bad = 0;

  match_controller #(
    .TICKS_PER_SEC(26'd4),
    .MATCH_SECONDS(7'd5),
    .KICKOFF_SECONDS(3'd2),
    .GOAL_PAUSE_SECONDS(3'd1),
    .MAX_SCORE(4'd3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .startButton(startButton),
    .pauseButton(pauseButton),
    .goal(goal),
    .gameStart(gameStart),
    .ballReset(ballReset),
    .scoreA(scoreA),
    .scoreB(scoreB),
    .timeLeft(timeLeft),
    .countdown(countdown),
    .winner(winner),
    .matchState(matchState)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       st;
    logic       pa;
    logic [1:0] go;
    int n;
    int state, tl, sa, sb, cd, gs, br, win;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic st, input logic pa,
                             input logic [1:0] go, input int n,
                             input int state, input int tl,
                             input int sa, input int sb, input int cd,
                             input int gs, input int br, input int win);
    vec_t r;
    r.st = st; r.pa = pa; r.go = go; r.n = n;
    r.state = state; r.tl = tl; r.sa = sa; r.sb = sb;
    r.cd = cd; r.gs = gs; r.br = br; r.win = win;
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int state, input int tl,
                         input int sa, input int sb, input int cd,
                         input int gs, input int br, input int win);
    chk({tag, ".state"}, int'(matchState), state);
    chk({tag, ".timeLeft"}, int'(timeLeft), tl);
    chk({tag, ".scoreA"}, int'(scoreA), sa);
    chk({tag, ".scoreB"}, int'(scoreB), sb);
    chk({tag, ".countdown"}, int'(countdown), cd);
    chk({tag, ".gameStart"}, int'(gameStart), gs);
    chk({tag, ".ballReset"}, int'(ballReset), br);
    chk({tag, ".winner"}, int'(winner), win);
  endtask

  task automatic go_to_play();
    startButton = 1'b1;
    tick(1);
    startButton = 1'b0;
    tick(9);
    chk("to_play.state", int'(matchState), 2);
  endtask

  task automatic goal_then_play(input logic [1:0] g);
    goal = g;
    tick(1);
    goal = 2'b00;
    tick(1);
    chk("gtp.gp", int'(matchState), 4);
    tick(4);
    chk("gtp.kick", int'(matchState), 1);
    tick(8);
    chk("gtp.play", int'(matchState), 2);
  endtask

  initial begin
    reset = 1'b1;
    startButton = 1'b0;
    pauseButton = 1'b0;
    goal = 2'b00;

    // Start, full-length match with no goals.
    vecs.push_back(v(1,0,0,1,  0,5,0,0,0,0,1,0));
    vecs.push_back(v(0,0,0,1,  1,5,0,0,2,0,1,0));
    vecs.push_back(v(0,0,0,3,  1,5,0,0,2,0,1,0));
    vecs.push_back(v(0,0,0,1,  1,5,0,0,1,0,1,0));
    vecs.push_back(v(0,0,0,3,  1,5,0,0,1,0,1,0));
    vecs.push_back(v(0,0,0,1,  2,5,0,0,0,1,0,0));
    vecs.push_back(v(0,0,0,4,  2,4,0,0,0,1,0,0));
    vecs.push_back(v(0,0,0,12, 2,1,0,0,0,1,0,0));
    vecs.push_back(v(0,0,0,3,  2,1,0,0,0,1,0,0));
    vecs.push_back(v(0,0,0,1,  5,0,0,0,0,0,0,3));
    vecs.push_back(v(1,0,0,1,  5,0,0,0,0,0,0,3));
    vecs.push_back(v(0,0,0,1,  0,5,0,0,0,0,1,0));
    // Held right-goal scores once, then goal pause and kickoff.
    vecs.push_back(v(1,0,0,1,  0,5,0,0,0,0,1,0));
    vecs.push_back(v(0,0,0,1,  1,5,0,0,2,0,1,0));
    vecs.push_back(v(0,0,0,7,  1,5,0,0,1,0,1,0));
    vecs.push_back(v(0,0,0,1,  2,5,0,0,0,1,0,0));
    vecs.push_back(v(0,0,3,1,  2,5,0,0,0,1,0,0));
    vecs.push_back(v(0,0,3,1,  4,5,1,0,0,0,1,0));
    vecs.push_back(v(0,0,3,1,  4,5,1,0,0,0,1,0));
    vecs.push_back(v(0,0,0,2,  4,5,1,0,0,0,1,0));
    vecs.push_back(v(0,0,0,1,  1,5,1,0,2,0,1,0));
    vecs.push_back(v(0,0,0,7,  1,5,1,0,1,0,1,0));
    vecs.push_back(v(0,0,0,1,  2,5,1,0,0,1,0,0));
    // Three left goals; the third reaches the max score.
    for (int k = 1; k <= 2; k++) begin
      vecs.push_back(v(0,0,2,1, 2,5,1,k-1,0,1,0,0));
      vecs.push_back(v(0,0,0,1, 4,5,1,k,0,0,1,0));
      vecs.push_back(v(0,0,0,3, 4,5,1,k,0,0,1,0));
      vecs.push_back(v(0,0,0,1, 1,5,1,k,2,0,1,0));
      vecs.push_back(v(0,0,0,7, 1,5,1,k,1,0,1,0));
      vecs.push_back(v(0,0,0,1, 2,5,1,k,0,1,0,0));
    end
    vecs.push_back(v(0,0,2,1,  2,5,1,2,0,1,0,0));
    vecs.push_back(v(0,0,0,1,  5,5,1,3,0,0,0,2));
    vecs.push_back(v(1,0,0,1,  5,5,1,3,0,0,0,2));
    vecs.push_back(v(0,0,0,1,  0,5,0,0,0,0,1,0));

    tick(2);
    chk_all("reset", 0,5,0,0,0,0,1,0);
    reset = 1'b0;
    tick(1);
    chk_all("post_reset", 0,5,0,0,0,0,1,0);

    foreach (vecs[i]) begin
      startButton = vecs[i].st;
      pauseButton = vecs[i].pa;
      goal        = vecs[i].go;
      tick(vecs[i].n);
      chk_all($sformatf("vec%0d", i), vecs[i].state, vecs[i].tl,
              vecs[i].sa, vecs[i].sb, vecs[i].cd, vecs[i].gs,
              vecs[i].br, vecs[i].win);
    end
    startButton = 1'b0;
    pauseButton = 1'b0;
    goal = 2'b00;

    // Pause at tickCnt=2 with start pressed together; goal while paused.
    go_to_play();
    tick(1);
    startButton = 1'b1;
    pauseButton = 1'b1;
    tick(1);
    chk("pause.press", int'(matchState), 2);
    tick(1);
    chk_all("pause.in", 3,5,0,0,0,0,0,0);
    goal = 2'b11;
    tick(1);
    goal = 2'b00;
    tick(9);
    chk_all("pause.held", 3,5,0,0,0,0,0,0);
    startButton = 1'b0;
    pauseButton = 1'b0;
    tick(1);
    pauseButton = 1'b1;
    tick(1);
    chk("resume.press", int'(matchState), 3);
    tick(1);
    chk_all("resume", 2,5,0,0,0,1,0,0);
    tick(1);
    chk("resume.r1.tl", int'(timeLeft), 5);
    tick(1);
    chk("resume.r2.tl", int'(timeLeft), 4);
    pauseButton = 1'b0;

    // Goal coinciding with the final second tick.
    tick(14);
    chk("final.pre.tl", int'(timeLeft), 1);
    goal = 2'b11;
    tick(1);
    chk("final.edge.state", int'(matchState), 2);
    chk("final.edge.sa", int'(scoreA), 0);
    goal = 2'b00;
    tick(1);
    chk_all("final", 5,0,1,0,0,0,0,1);

    // Reset in the middle of a goal pause at 2:1.
    startButton = 1'b1;
    tick(1);
    startButton = 1'b0;
    tick(1);
    chk("rst.idle", int'(matchState), 0);
    go_to_play();
    goal_then_play(2'b11);
    goal_then_play(2'b10);
    goal = 2'b11;
    tick(1);
    goal = 2'b00;
    tick(1);
    chk_all("rst.gp", 4,5,2,1,0,0,1,0);
    tick(1);
    reset = 1'b1;
    tick(1);
    chk_all("rst.applied", 0,5,0,0,0,0,1,0);
    reset = 1'b0;
    tick(1);
    chk_all("rst.after", 0,5,0,0,0,0,1,0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/match_controller.md
# match_controller

Top-level match sequencer for the head-soccer game. It owns the match state (idle, kickoff countdown, live play, pause, post-goal pause, game over), the two score counters and the match clock. It gates the ball physics through `gameStart` and re-centres the ball through `ballReset`. It sits between the board buttons and the ball/player datapath, and its score and timer outputs feed the HUD renderer.

## Interface
Parameters:
- `TICKS_PER_SEC`, 26'd50_000_000: clock cycles per game second.
- `MATCH_SECONDS`, 7'd90: match length in seconds.
- `KICKOFF_SECONDS`, 3'd3: kickoff countdown length.
- `GOAL_PAUSE_SECONDS`, 3'd2: freeze length after a goal.
- `MAX_SCORE`, 4'd9: score that ends the match immediately.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `startButton` in 1: level input from a debounced button, rising-edge detected.
- `pauseButton` in 1: level input from a debounced button, rising-edge detected.
- `goal` in 2: from the ball block. `2'b11` means the ball entered the right goal, which scores for player A. `2'b10` means the left goal, which scores for player B. Other values mean no goal.
- `gameStart` out 1: ball physics enable.
- `ballReset` out 1: holds the ball at the centre spawn.
- `scoreA`, `scoreB` out 4: scores.
- `timeLeft` out 7: remaining match seconds.
- `countdown` out 3: remaining kickoff seconds; 0 outside KICKOFF.
- `winner` out 2: 00 none, 01 A, 10 B, 11 draw.
- `matchState` out 3: encoded state for the HUD. IDLE=0, KICKOFF=1, PLAY=2, PAUSED=3, GOAL_PAUSE=4, GAME_OVER=5.

## Operation
- Edge detect: `startEdge = startButton & ~startPrev`. `pauseEdge` and `goalEdge = goal[1] & ~goalPrev` are formed the same way. All `*Prev` registers reset to 0.
- Prescaler: `tickCnt` counts 0..TICKS_PER_SEC-1. `secTick` is asserted on the cycle `tickCnt == TICKS_PER_SEC-1`, and `tickCnt` wraps to 0 on that cycle.
  - Counts only in KICKOFF, PLAY and GOAL_PAUSE.
  - Held in PAUSED.
  - Cleared to 0 on every other state transition and in IDLE and GAME_OVER.
- IDLE:
  - Outputs: `ballReset`=1, `gameStart`=0.
  - Scores are cleared, `timeLeft` is set to MATCH_SECONDS and `winner` is set to 00.
  - `startEdge` -> KICKOFF, loading `countdown`=KICKOFF_SECONDS.
- KICKOFF:
  - Outputs: `ballReset`=1, `gameStart`=0.
  - `countdown` decrements on each `secTick`.
  - The tick that takes it 1->0 moves to PLAY.
- PLAY:
  - Outputs: `ballReset`=0, `gameStart`=1.
  - `timeLeft` decrements on each `secTick`.
  - Priority 1: on `goalEdge`, increment the scorer (saturating at MAX_SCORE). If the new score equals MAX_SCORE, go to GAME_OVER; otherwise go to GOAL_PAUSE, loading `pauseCnt`=GOAL_PAUSE_SECONDS.
  - Priority 2: a `secTick` that takes `timeLeft` 1->0 goes to GAME_OVER.
  - Priority 3: `pauseEdge` goes to PAUSED.
  - Goal and final tick on the same cycle: the goal is counted, `timeLeft` becomes 0, and the next state is GAME_OVER.
- PAUSED:
  - Outputs: `gameStart`=0, `ballReset`=0, so the ball is frozen in place.
  - `timeLeft` and `tickCnt` are held.
  - `pauseEdge` returns to PLAY.
  - Goals are ignored, and `goalPrev` still tracks `goal`.
- GOAL_PAUSE:
  - Outputs: `ballReset`=1, `gameStart`=0.
  - `timeLeft` is frozen.
  - `pauseCnt` decrements on `secTick`. On 1->0, go to KICKOFF, loading `countdown`=KICKOFF_SECONDS.
- GAME_OVER:
  - Outputs: `gameStart`=0, `ballReset`=0.
  - `winner` is registered on entry: A>B gives 01, B>A gives 10, equal gives 11.
  - `startEdge` -> IDLE.
- `goal` values other than 1x are ignored in all states. Goals outside PLAY never score.
- Width rules:
  - Scores and `timeLeft` never wrap.
  - `timeLeft` is never decremented below 0.
  - Scores never exceed MAX_SCORE.

## Timing
- All state and counters are registered. `gameStart`, `ballReset` and `matchState` are Moore decodes of the state register; there is no input-to-output combinational path.
- Reset values: state IDLE, `ballReset`=1, `gameStart`=0, scores 0, `timeLeft`=MATCH_SECONDS, `countdown`=0, `winner`=00, `matchState`=0.
- Reset asserted in any state returns to these values on the next edge. It overrides every other event on the same cycle.
- Edge detection response: an input rising edge sampled at edge n changes the state at edge n+1. The edge detectors add one cycle before that.
- KICKOFF lasts exactly KICKOFF_SECONDS×TICKS_PER_SEC cycles.
- GOAL_PAUSE lasts exactly GOAL_PAUSE_SECONDS×TICKS_PER_SEC cycles.
- A PLAY period uninterrupted by goal or pause spans exactly MATCH_SECONDS×TICKS_PER_SEC cycles.
- A held button produces one edge only. Both buttons rising together in PLAY: pause applies (start is ignored in PLAY).

## Test plan
All scenarios use TICKS_PER_SEC=4, MATCH_SECONDS=5, KICKOFF_SECONDS=2, GOAL_PAUSE_SECONDS=1, MAX_SCORE=3.
- Reset then start pulse: KICKOFF for 8 cycles with `countdown` 2,1, then PLAY with `gameStart`=1. With no goals, GAME_OVER after 20 cycles, `timeLeft`=0, `winner`=11.
- `goal`=11 held for 3 cycles in PLAY: `scoreA`=1 exactly once. GOAL_PAUSE for 4 cycles with `ballReset`=1, then KICKOFF, and `timeLeft` is unchanged across the pauses.
- Three left-goal pulses (`goal`=10), each in a fresh PLAY: `scoreB`=3, then GAME_OVER immediately and `winner`=10.
- Pause in PLAY with `tickCnt`=2, hold 10 cycles, then pause again: `timeLeft` is unchanged while paused. The next decrement comes 2 cycles after resume, and a goal pulse while paused is not scored.
- Goal pulse on the same cycle as the final 1->0 tick with A at 0: `scoreA`=1, `timeLeft`=0, state GAME_OVER, `winner`=01.
- Reset asserted mid-GOAL_PAUSE with scores 2:1: next cycle state IDLE, scores 0:0, `timeLeft`=5, `ballReset`=1, `gameStart`=0.
